// File: rtl/time_keeper.sv
// time_keeper: 24-hour BCD alarm-clock core.
// Counts hh:mm:ss from the divider's 1 Hz square wave, accepts time-set loads,
// compares the running time against the alarm setting and runs the
// ring/snooze state machine that drives the buzzer enable.
// Optional build macro: RING_BLINK_EN (buzzer pulses with sec_tick_in while ringing).
module time_keeper #(
    parameter int RING_SECONDS = 60,
    parameter int SNOOZE_MIN   = 5
) (
    input  logic       CLK100MHZ,
    input  logic       reset,
    input  logic       sec_tick_in,
    input  logic       load,
    input  logic [7:0] set_hh,
    input  logic [7:0] set_mm,
    input  logic [7:0] alarm_hh,
    input  logic [7:0] alarm_mm,
    input  logic       alarm_arm,
    input  logic       snooze,
    input  logic       dismiss,
    output logic [7:0] hh,
    output logic [7:0] mm,
    output logic [7:0] ss,
    output logic       sec_pulse,
    output logic       load_err,
    output logic       alarm_ring
);

    localparam logic [7:0] RING_LIMIT  = 8'(RING_SECONDS);
    localparam logic [9:0] SNOOZE_LOAD = 10'(SNOOZE_MIN * 60);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RINGING  = 2'd1,
        SNOOZING = 2'd2
    } state_t;

    // Both digits legal and the packed value no larger than max_v.
    function automatic logic bcd_ok(input logic [7:0] v, input logic [7:0] max_v);
        return (v[3:0] <= 4'd9) && (v[7:4] <= 4'd9) && (v <= max_v);
    endfunction

    // Two-digit BCD increment that wraps to 00 after last_v.
    function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] last_v);
        if (v == last_v) begin
            return 8'h00;
        end else if (v[3:0] == 4'd9) begin
            return {v[7:4] + 4'd1, 4'd0};
        end else begin
            return {v[7:4], v[3:0] + 4'd1};
        end
    endfunction

    logic       tick_r;
    logic       sec_pulse_r;
    logic       load_err_r;
    logic [7:0] hh_r, mm_r, ss_r;
    logic [7:0] hh_nxt_s, mm_nxt_s, ss_nxt_s;
    logic [7:0] hh_inc_s, mm_inc_s, ss_inc_s;
    logic       rise_s;
    logic       set_ok_s;
    logic       load_ok_s;
    logic       match_s;
    state_t     state_r, state_nxt_s;
    logic [7:0] ring_cnt_r, ring_cnt_nxt_s;
    logic [9:0] snz_cnt_r, snz_cnt_nxt_s;

    assign rise_s    = sec_tick_in & ~tick_r;
    assign set_ok_s  = bcd_ok(set_hh, 8'h23) & bcd_ok(set_mm, 8'h59);
    assign load_ok_s = load & set_ok_s;

    // Ripple the one-second increment through the BCD fields and pick the next time.
    always_comb begin
        ss_inc_s = bcd_inc(ss_r, 8'h59);
        mm_inc_s = mm_r;
        hh_inc_s = hh_r;
        if (ss_r == 8'h59) begin
            mm_inc_s = bcd_inc(mm_r, 8'h59);
            if (mm_r == 8'h59) begin
                hh_inc_s = bcd_inc(hh_r, 8'h23);
            end else begin
                hh_inc_s = hh_r;
            end
        end else begin
            mm_inc_s = mm_r;
        end

        hh_nxt_s = hh_r;
        mm_nxt_s = mm_r;
        ss_nxt_s = ss_r;
        if (load_ok_s) begin
            // A load drops any coincident second.
            hh_nxt_s = set_hh;
            mm_nxt_s = set_mm;
            ss_nxt_s = 8'h00;
        end else if (rise_s) begin
            hh_nxt_s = hh_inc_s;
            mm_nxt_s = mm_inc_s;
            ss_nxt_s = ss_inc_s;
        end else begin
            ss_nxt_s = ss_r;
        end

        // Only a counted second can hit the alarm; loads never do.
        match_s = rise_s & ~load_ok_s & alarm_arm &
                  (hh_inc_s == alarm_hh) & (mm_inc_s == alarm_mm) & (ss_inc_s == 8'h00);
    end

    // Alarm state machine: next state and ring/snooze counters.
    always_comb begin
        state_nxt_s    = state_r;
        ring_cnt_nxt_s = ring_cnt_r;
        snz_cnt_nxt_s  = snz_cnt_r;
        if (!alarm_arm) begin
            state_nxt_s = IDLE;
        end else begin
            case (state_r)
                IDLE: begin
                    if (match_s && !dismiss) begin
                        state_nxt_s    = RINGING;
                        ring_cnt_nxt_s = 8'd0;
                    end else begin
                        state_nxt_s = IDLE;
                    end
                end
                RINGING: begin
                    if (dismiss) begin
                        state_nxt_s = IDLE;
                    end else if (snooze) begin
                        state_nxt_s   = SNOOZING;
                        snz_cnt_nxt_s = SNOOZE_LOAD;
                    end else if (rise_s) begin
                        if (ring_cnt_r >= RING_LIMIT - 8'd1) begin
                            ring_cnt_nxt_s = RING_LIMIT;
                            state_nxt_s    = IDLE;
                        end else begin
                            ring_cnt_nxt_s = ring_cnt_r + 8'd1;
                        end
                    end else begin
                        state_nxt_s = RINGING;
                    end
                end
                SNOOZING: begin
                    if (dismiss) begin
                        state_nxt_s = IDLE;
                    end else if (rise_s) begin
                        if (snz_cnt_r <= 10'd1) begin
                            snz_cnt_nxt_s  = 10'd0;
                            ring_cnt_nxt_s = 8'd0;
                            state_nxt_s    = RINGING;
                        end else begin
                            snz_cnt_nxt_s = snz_cnt_r - 10'd1;
                        end
                    end else begin
                        state_nxt_s = SNOOZING;
                    end
                end
                default: begin
                    state_nxt_s = IDLE;
                end
            endcase
        end
    end

    // State, time and strobe registers with synchronous reset.
    always_ff @(posedge CLK100MHZ) begin
        if (reset) begin
            tick_r      <= 1'b0;
            sec_pulse_r <= 1'b0;
            load_err_r  <= 1'b0;
            hh_r        <= 8'h00;
            mm_r        <= 8'h00;
            ss_r        <= 8'h00;
            state_r     <= IDLE;
            ring_cnt_r  <= 8'd0;
            snz_cnt_r   <= 10'd0;
        end else begin
            tick_r      <= sec_tick_in;
            sec_pulse_r <= rise_s;
            load_err_r  <= load & ~set_ok_s;
            hh_r        <= hh_nxt_s;
            mm_r        <= mm_nxt_s;
            ss_r        <= ss_nxt_s;
            state_r     <= state_nxt_s;
            ring_cnt_r  <= ring_cnt_nxt_s;
            snz_cnt_r   <= snz_cnt_nxt_s;
        end
    end

    assign hh        = hh_r;
    assign mm        = mm_r;
    assign ss        = ss_r;
    assign sec_pulse = sec_pulse_r;
    assign load_err  = load_err_r;

`ifdef RING_BLINK_EN
    assign alarm_ring = (state_r == RINGING) & sec_tick_in;
`else
    assign alarm_ring = (state_r == RINGING);
`endif

endmodule

// File: tb/tb_time_keeper.sv
// Bench for time_keeper: directed scenarios plus randomized traffic, checked
// against a seconds-of-day reference model through a strobe scoreboard.
module tb_time_keeper;

    localparam int RS = 4;
    localparam int SM = 1;
`ifdef RING_BLINK_EN
    localparam bit BLINK = 1'b1;
`else
    localparam bit BLINK = 1'b0;
`endif

    logic       CLK100MHZ = 1'b0;
    logic       reset = 1'b1;
    logic       sec_tick_in = 1'b0;
    logic       load = 1'b0;
    logic [7:0] set_hh = 8'h00, set_mm = 8'h00;
    logic [7:0] alarm_hh = 8'h00, alarm_mm = 8'h00;
    logic       alarm_arm = 1'b0, snooze = 1'b0, dismiss = 1'b0;
    logic [7:0] hh, mm, ss;
    logic       sec_pulse, load_err, alarm_ring;

    time_keeper #(.RING_SECONDS(RS), .SNOOZE_MIN(SM)) dut (
        .CLK100MHZ(CLK100MHZ), .reset(reset), .sec_tick_in(sec_tick_in),
        .load(load), .set_hh(set_hh), .set_mm(set_mm),
        .alarm_hh(alarm_hh), .alarm_mm(alarm_mm), .alarm_arm(alarm_arm),
        .snooze(snooze), .dismiss(dismiss),
        .hh(hh), .mm(mm), .ss(ss), .sec_pulse(sec_pulse),
        .load_err(load_err), .alarm_ring(alarm_ring)
    );

    always #5 CLK100MHZ = ~CLK100MHZ;

    typedef struct {
        bit pulse;
        bit err;
        int secs;
    } ev_t;

    ev_t q[$];
    int  total = 0;
    int  bad = 0;

    // Reference state: time as seconds of day; alarm as remaining-seconds counters.
    int m_secs = 0;
    bit m_prev = 1'b0;
    int m_ring = 0;
    int m_snz = 0;

    function automatic int bcd2i(input logic [7:0] v);
        return int'(v[7:4]) * 10 + int'(v[3:0]);
    endfunction

    function automatic logic [23:0] secs2bcd(input int s);
        int h, m, x;
        h = s / 3600;
        m = (s / 60) % 60;
        x = s % 60;
        return {8'(((h / 10) << 4) | (h % 10)), 8'(((m / 10) << 4) | (m % 10)),
                8'(((x / 10) << 4) | (x % 10))};
    endfunction

    function automatic bit legal(input logic [7:0] v, input int maxv);
        return (v[3:0] <= 4'd9) && (v[7:4] <= 4'd9) && (bcd2i(v) <= maxv);
    endfunction

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        bit  rise, ok, bad_load, match;
        ev_t e;
        if (reset) begin
            m_secs = 0;
            m_prev = 1'b0;
            m_ring = 0;
            m_snz  = 0;
        end else begin
            rise     = sec_tick_in && !m_prev;
            m_prev   = sec_tick_in;
            ok       = load && legal(set_hh, 23) && legal(set_mm, 59);
            bad_load = load && !ok;
            match    = 1'b0;
            if (ok) begin
                m_secs = bcd2i(set_hh) * 3600 + bcd2i(set_mm) * 60;
            end else if (rise) begin
                m_secs = (m_secs + 1) % 86400;
                match  = alarm_arm && m_ring == 0 && m_snz == 0 &&
                         m_secs == bcd2i(alarm_hh) * 3600 + bcd2i(alarm_mm) * 60;
            end
            if (!alarm_arm || dismiss) begin
                m_ring = 0;
                m_snz  = 0;
            end else if (m_ring > 0 && snooze) begin
                m_ring = 0;
                m_snz  = SM * 60;
            end else if (rise) begin
                if (m_ring > 0) begin
                    m_ring--;
                end else if (m_snz > 0) begin
                    m_snz--;
                    if (m_snz == 0) m_ring = RS;
                end else if (match) begin
                    m_ring = RS;
                end
            end
            if (rise || bad_load) begin
                e.pulse = rise;
                e.err   = bad_load;
                e.secs  = m_secs;
                q.push_back(e);
            end
        end
    endtask

    // Reference model advances on every active edge.
    initial forever begin
        @(posedge CLK100MHZ);
        model_step();
    end

    // Monitor: pop an expectation on every strobe, and track the buzzer each cycle.
    initial forever begin
        ev_t e;
        @(negedge CLK100MHZ);
        if (sec_pulse || load_err) begin
            if (q.size() == 0) begin
                check("unexpected_strobe", {sec_pulse, load_err}, 0);
            end else begin
                e = q.pop_front();
                check("sec_pulse", sec_pulse, e.pulse);
                check("load_err", load_err, e.err);
                check("time", {hh, mm, ss}, secs2bcd(e.secs));
            end
        end
        check("alarm_ring", alarm_ring, (m_ring > 0) && (!BLINK || sec_tick_in));
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge CLK100MHZ);
            #1;
        end
    endtask

    task automatic secs(input int n);
        repeat (n) begin
            sec_tick_in = 1'b1;
            cyc(3);
            sec_tick_in = 1'b0;
            cyc(3);
        end
    endtask

    // One second, checking the buzzer while the tick is high.
    task automatic tick_ring(input bit exp);
        sec_tick_in = 1'b1;
        cyc(1);
        check("ring_direct", alarm_ring, exp);
        cyc(2);
        sec_tick_in = 1'b0;
        cyc(3);
    endtask

    task automatic do_load(input logic [7:0] h, input logic [7:0] m);
        set_hh = h;
        set_mm = m;
        load   = 1'b1;
        cyc(1);
        load   = 1'b0;
        cyc(1);
    endtask

    initial begin
        bit prev_t;
        reset = 1'b1;
        cyc(3);
        check("reset_time", {hh, mm, ss}, 0);
        check("reset_strobes", {sec_pulse, load_err, alarm_ring}, 0);
        reset = 1'b0;
        cyc(2);

        secs(3);
        check("three_secs", {hh, mm, ss}, 24'h000003);

        do_load(8'h23, 8'h59);
        secs(59);
        check("t_235959", {hh, mm, ss}, 24'h235959);
        secs(1);
        check("midnight_wrap", {hh, mm, ss}, 24'h000000);

        do_load(8'h24, 8'h59);
        do_load(8'h12, 8'h5A);
        do_load(8'h1A, 8'h00);
        check("bad_load_keeps_time", {hh, mm, ss}, 24'h000000);

        set_hh = 8'h12;
        set_mm = 8'h34;
        load = 1'b1;
        sec_tick_in = 1'b1;
        cyc(1);
        load = 1'b0;
        cyc(2);
        sec_tick_in = 1'b0;
        cyc(3);
        check("load_on_rise", {hh, mm, ss}, 24'h123400);

        alarm_hh = 8'h07;
        alarm_mm = 8'h00;
        alarm_arm = 1'b1;
        do_load(8'h07, 8'h00);
        tick_ring(1'b0);
        do_load(8'h06, 8'h59);
        secs(59);
        tick_ring(1'b1);
        tick_ring(1'b1);
        tick_ring(1'b1);
        tick_ring(1'b1);
        tick_ring(1'b0);

        alarm_arm = 1'b0;
        do_load(8'h06, 8'h59);
        secs(59);
        tick_ring(1'b0);

        alarm_arm = 1'b1;
        do_load(8'h06, 8'h59);
        secs(59);
        tick_ring(1'b1);
        snooze = 1'b1;
        cyc(1);
        snooze = 1'b0;
        secs(58);
        tick_ring(1'b0);
        tick_ring(1'b1);
        snooze = 1'b1;
        dismiss = 1'b1;
        cyc(1);
        snooze = 1'b0;
        dismiss = 1'b0;
        tick_ring(1'b0);

        do_load(8'h06, 8'h59);
        secs(59);
        sec_tick_in = 1'b1;
        cyc(1);
        check("ring_before_reset", alarm_ring, 1);
        reset = 1'b1;
        cyc(1);
        check("reset_ring_time", {hh, mm, ss}, 0);
        check("reset_ring_strobes", {sec_pulse, load_err, alarm_ring}, 0);
        sec_tick_in = 1'b0;
        cyc(2);
        reset = 1'b0;
        cyc(4);
        check("no_pulse_after_reset", sec_pulse, 0);

        alarm_hh = 8'h07;
        alarm_mm = 8'h00;
        alarm_arm = 1'b1;
        do_load(8'h06, 8'h58);
        prev_t = sec_tick_in;
        for (int i = 0; i < 3000; i++) begin
            int r;
            prev_t = sec_tick_in;
            if ($urandom_range(0, 3) == 0) sec_tick_in = ~sec_tick_in;
            r = $urandom_range(0, 99);
            if (r < 3 && !(sec_tick_in && !prev_t)) begin
                load   = 1'b1;
                set_hh = (r == 0) ? 8'($urandom_range(0, 255)) : 8'h06;
                set_mm = (r == 0) ? 8'($urandom_range(0, 255)) : 8'h59;
            end
            snooze    = (r >= 3 && r < 6);
            dismiss   = (r == 6);
            if (r == 7) alarm_arm = 1'b0;
            if (r >= 8 && r < 12) alarm_arm = 1'b1;
            cyc(1);
            load    = 1'b0;
            snooze  = 1'b0;
            dismiss = 1'b0;
        end
        sec_tick_in = 1'b0;
        cyc(5);
        check("queue_drain", q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
